// File: rtl/grf_wb_arbiter_if.sv
// Bus bundle for the GRF write-port arbiter: W-stage writeback, MDU result path,
// GRF write port and the hazard lookup / stall request signals.
interface grf_wb_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd;
    logic [31:0] pipe_pc;

    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_a3;
    logic [31:0] mdu_wd;
    logic [31:0] mdu_pc;

    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;

    logic [4:0]  hz_a;
    logic        hz_busy;
    logic        stall_pipe;

    modport slave (
        input  pipe_we, pipe_a3, pipe_wd, pipe_pc,
        input  mdu_valid, mdu_a3, mdu_wd, mdu_pc,
        input  hz_a,
        output mdu_ready, grf_we, grf_a3, grf_wd, grf_pc, hz_busy, stall_pipe
    );

    modport master (
        output pipe_we, pipe_a3, pipe_wd, pipe_pc,
        output mdu_valid, mdu_a3, mdu_wd, mdu_pc,
        output hz_a,
        input  mdu_ready, grf_we, grf_a3, grf_wd, grf_pc, hz_busy, stall_pipe
    );
endinterface

// File: rtl/grf_wb_arbiter.sv
// Shares the single GRF write port between W-stage writeback (always wins) and a
// FIFO of pending MDU results that drain on idle port cycles.
module grf_wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    grf_wb_arbiter_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [4:0]       entA3 [DEPTH];
    logic [31:0]      entWd [DEPTH];
    logic [31:0]      entPc [DEPTH];
    logic [DEPTH-1:0] entValid;

    logic [AW:0]   rdPtr;
    logic [AW:0]   wrPtr;
    logic [AW:0]   count;
    logic [AW-1:0] headIdx;
    logic [AW-1:0] tailIdx;
    logic          empty;
    logic          full;
    logic          pipeLive;
    logic          headValid;
    logic          blocked;
    logic          pop;
    logic          push;
    logic [CW-1:0] waitCnt;
    logic          stallReg;

    assign headIdx   = rdPtr[AW-1:0];
    assign tailIdx   = wrPtr[AW-1:0];
    assign count     = wrPtr - rdPtr;
    assign empty     = (rdPtr == wrPtr);
    assign full      = (rdPtr[AW] != wrPtr[AW]) && (rdPtr[AW-1:0] == wrPtr[AW-1:0]);
    assign pipeLive  = bus.pipe_we && (bus.pipe_a3 != 5'd0);
    assign headValid = !empty && entValid[headIdx];
    assign blocked   = headValid && pipeLive;
    // A squashed head never needs the port, so it leaves even under a live pipe write.
    assign pop       = !empty && (!entValid[headIdx] || !pipeLive);
    assign push      = bus.mdu_valid && bus.mdu_ready;

    assign bus.mdu_ready  = !full && !reset;
    assign bus.stall_pipe = stallReg;

    // Port grant: pipeline first, then a valid FIFO head, otherwise the port is idle.
    always_comb begin
        bus.grf_we = 1'b0;
        bus.grf_a3 = 5'd0;
        bus.grf_wd = 32'd0;
        bus.grf_pc = 32'd0;
        if (!reset) begin
            if (pipeLive) begin
                bus.grf_we = 1'b1;
                bus.grf_a3 = bus.pipe_a3;
                bus.grf_wd = bus.pipe_wd;
                bus.grf_pc = bus.pipe_pc;
            end else if (headValid) begin
                bus.grf_we = 1'b1;
                bus.grf_a3 = entA3[headIdx];
                bus.grf_wd = entWd[headIdx];
                bus.grf_pc = entPc[headIdx];
            end
        end
    end

    // Hazard lookup walks only the occupied slots, starting at the head.
    always_comb begin
        logic          busy;
        logic [AW-1:0] slot;
        busy = 1'b0;
        slot = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = headIdx + AW'(k);
            if (((AW+1)'(k) < count) && entValid[slot] && (entA3[slot] == bus.hz_a)) begin
                busy = 1'b1;
            end
        end
        bus.hz_busy = busy && (bus.hz_a != 5'd0) && !reset;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entA3[tailIdx] <= bus.mdu_a3;
            entWd[tailIdx] <= bus.mdu_wd;
            entPc[tailIdx] <= bus.mdu_pc;
        end
    end

    // The enqueue assignment comes after the squash loop so a same-cycle MDU result survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            entValid <= '0;
        end else begin
            if (pipeLive) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entA3[i] == bus.pipe_a3) begin
                        entValid[i] <= 1'b0;
                    end
                end
            end
            if (push) begin
                entValid[tailIdx] <= (bus.mdu_a3 != 5'd0);
                wrPtr             <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

    // Starvation tracking: count blocked cycles of the current head, request a bubble at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waitCnt  <= '0;
            stallReg <= 1'b0;
        end else begin
            if (pop || empty) begin
                waitCnt <= '0;
            end else if (blocked && (waitCnt < CW'(MAX_WAIT - 1))) begin
                waitCnt <= waitCnt + 1'b1;
            end
            if (pop) begin
                stallReg <= 1'b0;
            end else if (blocked && (waitCnt == CW'(MAX_WAIT - 1))) begin
                stallReg <= 1'b1;
            end
        end
    end
endmodule
